// File: rtl/mem_arb.sv
//------------------------------------------------------------------------------
// mem_arb -- two-requester single-port memory arbiter, fixed 3-cycle latency.
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mem_arb #(
   parameter int WIDTH     = 32,
   parameter int ADDR_SIZE = 17,
   parameter int PRIO_MODE = 0
) (
   input  logic                 clk,
   input  logic                 reset,

   input  logic                 m0_req,
   input  logic                 m0_wen,
   input  logic [ADDR_SIZE-1:0] m0_addr,
   input  logic [WIDTH-1:0]     m0_wdata,
   output logic                 m0_ack,
   output logic [WIDTH-1:0]     m0_rdata,

   input  logic                 m1_req,
   input  logic                 m1_wen,
   input  logic [ADDR_SIZE-1:0] m1_addr,
   input  logic [WIDTH-1:0]     m1_wdata,
   output logic                 m1_ack,
   output logic [WIDTH-1:0]     m1_rdata,

   output logic                 mem_cs,
   output logic                 mem_wen,
   output logic [ADDR_SIZE-1:0] mem_addr,
   output logic [WIDTH-1:0]     mem_wdata,
   input  logic [WIDTH-1:0]     mem_rdata,

   output logic                 busy,
   output logic                 gnt
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   logic [1:0]           state;
   logic [1:0]           next_state;
   logic                 any_req;
   logic                 win;
   logic                 lat_wen;
   logic [ADDR_SIZE-1:0] lat_addr;
   logic [WIDTH-1:0]     lat_wdata;

   assign any_req = m0_req | m1_req;

   // gnt holds the last-served index, so on a tie the other requester wins.
   always_comb begin
      win = gnt;
      if (m0_req && m1_req) begin
         win = (PRIO_MODE == 1) ? 1'b0 : ~gnt;
      end else if (m0_req) begin
         win = 1'b0;
      end else if (m1_req) begin
         win = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    next_state = any_req ? ACCESS : IDLE;
         ACCESS:  next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      mem_cs    = (state == ACCESS);
      mem_wen   = (state == ACCESS) & lat_wen;
      mem_addr  = lat_addr;
      mem_wdata = lat_wdata;
      busy      = (state != IDLE);
   end

   // Request latch, grant and per-requester response registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lat_wen   <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         gnt       <= 1'b1;
         m0_ack    <= 1'b0;
         m1_ack    <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
      end else begin
         m0_ack <= 1'b0;
         m1_ack <= 1'b0;
         if (state == IDLE && any_req) begin
            gnt       <= win;
            lat_wen   <= win ? m1_wen   : m0_wen;
            lat_addr  <= win ? m1_addr  : m0_addr;
            lat_wdata <= win ? m1_wdata : m0_wdata;
         end
         if (state == DONE) begin
            if (gnt) begin
               m1_rdata <= mem_rdata;
               m1_ack   <= 1'b1;
            end else begin
               m0_rdata <= mem_rdata;
               m0_ack   <= 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_arb.sv
//------------------------------------------------------------------------------
// tb_mem_arb -- vector table plus scoreboard bench for mem_arb (RR and fixed prio).
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arb;
   localparam int W = 32;
   localparam int A = 17;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic m0_req, m0_wen, m1_req, m1_wen;
   logic [A-1:0] m0_addr, m1_addr;
   logic [W-1:0] m0_wdata, m1_wdata;

   logic a_m0_ack, a_m1_ack, a_mem_cs, a_mem_wen, a_busy, a_gnt;
   logic [W-1:0] a_m0_rdata, a_m1_rdata, a_mem_wdata, a_mem_rdata;
   logic [A-1:0] a_mem_addr;
   logic b_m0_ack, b_m1_ack, b_mem_cs, b_mem_wen, b_busy, b_gnt;
   logic [W-1:0] b_m0_rdata, b_m1_rdata, b_mem_wdata, b_mem_rdata;
   logic [A-1:0] b_mem_addr;

   always #5 clk = ~clk;

   mem_arb #(.WIDTH(W), .ADDR_SIZE(A), .PRIO_MODE(0)) dut_a (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(a_m0_ack), .m0_rdata(a_m0_rdata),
      .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(a_m1_ack), .m1_rdata(a_m1_rdata),
      .mem_cs(a_mem_cs), .mem_wen(a_mem_wen), .mem_addr(a_mem_addr),
      .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
      .busy(a_busy), .gnt(a_gnt));

   mem_arb #(.WIDTH(W), .ADDR_SIZE(A), .PRIO_MODE(1)) dut_b (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
      .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
      .mem_cs(b_mem_cs), .mem_wen(b_mem_wen), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
      .busy(b_busy), .gnt(b_gnt));

   // Synchronous memories, read-before-write.
   logic [W-1:0] mem_a [logic [A-1:0]];
   logic [W-1:0] mem_b [logic [A-1:0]];

   always @(posedge clk) begin
      if (a_mem_cs) begin
         a_mem_rdata <= mem_a.exists(a_mem_addr) ? mem_a[a_mem_addr] : '0;
         if (a_mem_wen) mem_a[a_mem_addr] = a_mem_wdata;
      end
      if (b_mem_cs) begin
         b_mem_rdata <= mem_b.exists(b_mem_addr) ? mem_b[b_mem_addr] : '0;
         if (b_mem_wen) mem_b[b_mem_addr] = b_mem_wdata;
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: event occurred, expected none (t=%0t)", name, $time);
   endtask

   typedef struct {
      logic         gnt;
      logic [A-1:0] addr;
      logic         wen;
      logic [W-1:0] wdata;
      logic [W-1:0] rdata;
   } exp_t;

   exp_t sb[$];

   task automatic push(input logic g, input logic [A-1:0] addr, input logic wen,
                       input logic [W-1:0] wdata, input logic [W-1:0] rdata);
      exp_t e;
      e.gnt = g; e.addr = addr; e.wen = wen; e.wdata = wdata; e.rdata = rdata;
      sb.push_back(e);
   endtask

   // Monitor for the round-robin instance: memory port and completions vs scoreboard.
   logic [W-1:0] exp_rd [2];
   logic         prev_cs;
   exp_t         mon_e;

   always @(negedge clk) begin
      if (!reset) begin
         exp_rd[0] = '0;
         exp_rd[1] = '0;
         prev_cs   = 1'b0;
      end else begin
         if (!a_mem_cs) check("wen_without_cs", a_mem_wen, 1'b0);
         if (a_mem_cs) begin
            check("cs_back_to_back", prev_cs, 1'b0);
            if (sb.size() == 0) begin
               fail_now("cs_unexpected");
            end else begin
               check("mem_addr", a_mem_addr, sb[0].addr);
               check("mem_wen", a_mem_wen, sb[0].wen);
               if (sb[0].wen) check("mem_wdata", a_mem_wdata, sb[0].wdata);
            end
         end
         prev_cs = a_mem_cs;
         if (a_m0_ack || a_m1_ack) begin
            if (sb.size() == 0) begin
               fail_now("ack_unexpected");
            end else begin
               mon_e = sb.pop_front();
               check("ack_gnt", a_gnt, mon_e.gnt);
               check("ack_pair", {a_m1_ack, a_m0_ack}, mon_e.gnt ? 2'b10 : 2'b01);
               check("winner_rdata", mon_e.gnt ? a_m1_rdata : a_m0_rdata, mon_e.rdata);
               check("loser_rdata", mon_e.gnt ? a_m0_rdata : a_m1_rdata, exp_rd[!mon_e.gnt]);
               exp_rd[mon_e.gnt] = mon_e.rdata;
            end
         end
      end
   end

   task automatic wait_ack(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(a_m0_ack || a_m1_ack) && n < 20);
      if (!(a_m0_ack || a_m1_ack)) begin
         n_tests++;
         n_fail++;
         $display("FAIL ack_timeout: got no ack after %0d cycles, expected ack", n);
      end
   endtask

   task automatic check_reset_vals();
      check("rst_a_cs", a_mem_cs, 1'b0);       check("rst_b_cs", b_mem_cs, 1'b0);
      check("rst_a_wen", a_mem_wen, 1'b0);     check("rst_b_wen", b_mem_wen, 1'b0);
      check("rst_a_addr", a_mem_addr, '0);     check("rst_b_addr", b_mem_addr, '0);
      check("rst_a_wdata", a_mem_wdata, '0);   check("rst_b_wdata", b_mem_wdata, '0);
      check("rst_a_acks", {a_m1_ack, a_m0_ack}, 2'b00);
      check("rst_b_acks", {b_m1_ack, b_m0_ack}, 2'b00);
      check("rst_a_rd0", a_m0_rdata, '0);      check("rst_a_rd1", a_m1_rdata, '0);
      check("rst_b_rd0", b_m0_rdata, '0);      check("rst_b_rd1", b_m1_rdata, '0);
      check("rst_a_busy", a_busy, 1'b0);       check("rst_b_busy", b_busy, 1'b0);
      check("rst_a_gnt", a_gnt, 1'b1);         check("rst_b_gnt", b_gnt, 1'b1);
   endtask

   typedef struct {
      logic         m0_req;
      logic         m0_wen;
      logic [A-1:0] m0_addr;
      logic [W-1:0] m0_wdata;
      logic         m1_req;
      logic         m1_wen;
      logic [A-1:0] m1_addr;
      logic [W-1:0] m1_wdata;
      logic         exp_gnt;
      logic         exp_gnt_prio;
      logic [W-1:0] exp_rdata;
   } vec_t;

   vec_t vecs [8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int acks_seen;

      mem_a[17'h00000] = 32'h0BADF00D;  mem_b[17'h00000] = 32'h0BADF00D;
      mem_a[17'h00005] = 32'h55555555;  mem_b[17'h00005] = 32'h55555555;
      mem_a[17'h00010] = 32'hDEADBEEF;  mem_b[17'h00010] = 32'hDEADBEEF;
      mem_a[17'h00020] = 32'h20202020;  mem_b[17'h00020] = 32'h20202020;
      mem_a[17'h00030] = 32'h30303030;  mem_b[17'h00030] = 32'h30303030;

      m0_req = 0; m0_wen = 0; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_wen = 0; m1_addr = '0; m1_wdata = '0;

      //          m0 req/wen/addr/wdata           m1 req/wen/addr/wdata            gnt prio rdata
      vecs[0] = '{1'b1, 1'b0, 17'h00010, 32'h0,        1'b0, 1'b0, 17'h00000, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
      vecs[1] = '{1'b0, 1'b0, 17'h00000, 32'h0,        1'b1, 1'b1, 17'h1FFFF, 32'h12345678, 1'b1, 1'b1, 32'h00000000};
      vecs[2] = '{1'b0, 1'b0, 17'h00000, 32'h0,        1'b1, 1'b0, 17'h1FFFF, 32'h0,        1'b1, 1'b1, 32'h12345678};
      vecs[3] = '{1'b1, 1'b0, 17'h00020, 32'h0,        1'b1, 1'b0, 17'h00030, 32'h0,        1'b0, 1'b0, 32'h20202020};
      vecs[4] = '{1'b1, 1'b0, 17'h00020, 32'h0,        1'b1, 1'b0, 17'h00030, 32'h0,        1'b1, 1'b0, 32'h30303030};
      vecs[5] = '{1'b1, 1'b1, 17'h00000, 32'hA5A5A5A5, 1'b0, 1'b0, 17'h00000, 32'h0,        1'b0, 1'b0, 32'h0BADF00D};
      vecs[6] = '{1'b1, 1'b0, 17'h00000, 32'h0,        1'b0, 1'b0, 17'h00000, 32'h0,        1'b0, 1'b0, 32'hA5A5A5A5};
      vecs[7] = '{1'b1, 1'b0, 17'h00020, 32'h0,        1'b1, 1'b0, 17'h00010, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF};

      repeat (3) @(negedge clk);
      check_reset_vals();
      reset = 1'b1;

      // Table: each request is held for a single sampling edge only.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         m0_req = vecs[i].m0_req; m0_wen = vecs[i].m0_wen;
         m0_addr = vecs[i].m0_addr; m0_wdata = vecs[i].m0_wdata;
         m1_req = vecs[i].m1_req; m1_wen = vecs[i].m1_wen;
         m1_addr = vecs[i].m1_addr; m1_wdata = vecs[i].m1_wdata;
         if (vecs[i].exp_gnt)
            push(1'b1, vecs[i].m1_addr, vecs[i].m1_wen, vecs[i].m1_wdata, vecs[i].exp_rdata);
         else
            push(1'b0, vecs[i].m0_addr, vecs[i].m0_wen, vecs[i].m0_wdata, vecs[i].exp_rdata);
         @(negedge clk);
         check("busy_in_access", a_busy, 1'b1);
         check("cs_latency", a_mem_cs, 1'b1);
         m0_req = 0; m1_req = 0;
         wait_ack(n);
         check("ack_latency", n, 2);
         check("busy_ack_cycle", a_busy, 1'b0);
         check("prio_gnt", b_gnt, vecs[i].exp_gnt_prio);
         check("prio_ack", b_m0_ack | b_m1_ack, 1'b1);
      end

      // Contention from reset release: RR alternates, fixed priority starves m1.
      @(negedge clk);
      reset = 1'b0;
      m0_req = 1; m0_wen = 0; m0_addr = 17'h00020;
      m1_req = 1; m1_wen = 0; m1_addr = 17'h00030;
      push(1'b0, 17'h00020, 1'b0, '0, 32'h20202020);
      push(1'b1, 17'h00030, 1'b0, '0, 32'h30303030);
      push(1'b0, 17'h00020, 1'b0, '0, 32'h20202020);
      push(1'b1, 17'h00030, 1'b0, '0, 32'h30303030);
      push(1'b1, 17'h00030, 1'b0, '0, 32'h30303030);
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_ack(n);
         check("contention_spacing", n, 3);
         check("prio_only_m0", {b_m1_ack, b_m0_ack}, 2'b01);
         if (k == 3) m0_req = 0;
      end
      @(negedge clk);
      m1_req = 0;
      wait_ack(n);
      check("dropped_req_latency", n, 2);
      check("prio_m1_after_drop", {b_m1_ack, b_m0_ack}, 2'b10);

      // Inputs changed while in ACCESS must not reach the memory port.
      @(negedge clk);
      m0_req = 1; m0_wen = 0; m0_addr = 17'h00005;
      push(1'b0, 17'h00005, 1'b0, '0, 32'h55555555);
      @(negedge clk);
      m0_req = 0; m0_addr = 17'h00009; m0_wen = 1; m0_wdata = 32'hFFFFFFFF;
      #1;
      check("midflight_addr", a_mem_addr, 17'h00005);
      check("midflight_wen", a_mem_wen, 1'b0);
      wait_ack(n);
      check("midflight_latency", n, 2);
      m0_wen = 0;

      // Reset asserted during ACCESS aborts with no ack.
      @(negedge clk);
      m0_req = 1; m0_addr = 17'h00010;
      push(1'b0, 17'h00010, 1'b0, '0, 32'hDEADBEEF);
      @(negedge clk);
      #2;
      reset = 1'b0;
      m0_req = 0;
      sb.delete();
      #1;
      check_reset_vals();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      acks_seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (a_m0_ack || a_m1_ack || b_m0_ack || b_m1_ack) acks_seen++;
      end
      check("no_ack_after_abort", acks_seen, 0);

      // After the abort, the first tie goes to m0 again.
      @(negedge clk);
      m0_req = 1; m0_addr = 17'h00020;
      m1_req = 1; m1_addr = 17'h00030;
      push(1'b0, 17'h00020, 1'b0, '0, 32'h20202020);
      @(negedge clk);
      m0_req = 0; m1_req = 0;
      wait_ack(n);
      check("post_abort_gnt", a_gnt, 1'b0);

      repeat (2) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of both requesters and the memory port.
REQ-002 SHALL have parameter ADDR_SIZE, default 17: word address width.
REQ-003 SHALL have parameter PRIO_MODE, default 0: 0 selects round-robin arbitration, 1 selects fixed priority with m0 highest.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports m0_req, m0_wen, input, 1 bit each: requester 0 (CPU) access request and write enable.
REQ-007 SHALL have ports m0_addr (ADDR_SIZE bits) and m0_wdata (WIDTH bits), input: requester 0 address and write data.
REQ-008 SHALL have ports m0_ack (1 bit) and m0_rdata (WIDTH bits), output: requester 0 completion pulse and read data.
REQ-009 SHALL have ports m1_req, m1_wen, m1_addr, m1_wdata, m1_ack and m1_rdata, matching the m0 set: requester 1 (debug/DMA).
REQ-010 SHALL have ports mem_cs and mem_wen, output, 1 bit each: memory select and write enable.
REQ-011 SHALL have ports mem_addr (ADDR_SIZE bits) and mem_wdata (WIDTH bits), output: memory address and write data.
REQ-012 SHALL have port mem_rdata, input, WIDTH bits: synchronous memory read data, valid on the cycle after mem_cs.
REQ-013 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-014 SHALL have port gnt, output, 1 bit: index of the requester being served or last served.

Function
REQ-015 SHALL implement an FSM with exactly three states: IDLE, ACCESS and DONE.
REQ-016 In IDLE with any request high, the FSM SHALL select a winner, latch that requester's addr, wdata and wen into internal registers, set gnt, and go to ACCESS on the same edge.
REQ-017 In IDLE with no request high, the FSM SHALL remain in IDLE.
REQ-018 Winner selection, single request: that requester wins.
REQ-019 Winner selection, both requests, PRIO_MODE=0: the requester that is not gnt wins (round-robin).
REQ-020 Winner selection, both requests, PRIO_MODE=1: m0 always wins.
REQ-021 In ACCESS, mem_cs SHALL be 1 for exactly one cycle, with mem_addr, mem_wdata and mem_wen driven from the latched registers; the FSM then goes to DONE.
REQ-022 mem_cs SHALL be 0 in IDLE and DONE; mem_wen SHALL be 0 whenever mem_cs is 0.
REQ-023 On the DONE-state edge, the winner's mX_rdata SHALL register mem_rdata, for writes as well as reads; the FSM then goes to IDLE.
REQ-024 The winner's mX_ack SHALL be a registered one-cycle pulse, high in the cycle after DONE.
REQ-025 The loser's ack and rdata SHALL be unchanged by a transaction.
REQ-026 Latency SHALL be fixed at 3 cycles: request sampled in IDLE at edge N, mem_cs high in cycle N+1, ack high in cycle N+3.
REQ-027 Inputs SHALL be sampled only in IDLE; changes to req, addr, wdata or wen during ACCESS or DONE SHALL NOT affect the transaction in flight.
REQ-028 A transaction, once latched, SHALL complete and ack even if its req drops.
REQ-029 A req still high in the ack cycle SHALL be treated as a new request, with arbitration in that IDLE cycle.
REQ-030 Under continuous requests, throughput SHALL be one transaction per 3 cycles.
REQ-031 In PRIO_MODE=0, two continuously requesting masters SHALL strictly alternate grants.
REQ-032 Address and data SHALL pass through unmodified; there SHALL be no width conversion and no wrap logic.

Reset
REQ-033 While reset=0, the block SHALL hold: state IDLE, mem_cs=0, mem_wen=0, mem_addr=0, mem_wdata=0, m0_ack=m1_ack=0, m0_rdata=m1_rdata=0, busy=0, gnt=1 (so m0 wins the first tie).
REQ-034 Reset asserted mid-transaction SHALL abort it immediately with no ack; after release, arbitration SHALL restart from IDLE.

Verification
REQ-035 Single read: m0_req=1, addr=0x00010, memory holds 0xDEADBEEF -> mem_cs high 1 cycle with mem_addr=0x00010 and mem_wen=0; m0_ack pulses 3 cycles after sampling; m0_rdata=0xDEADBEEF.
REQ-036 Write then readback: m1 writes 0x12345678 to 0x1FFFF, then reads 0x1FFFF -> mem_wen=1 only in the first ACCESS cycle; m1_rdata=0x12345678; m0 outputs unchanged.
REQ-037 Contention, PRIO_MODE=0: both reqs held high from reset release -> grant order m0, m1, m0, m1; acks spaced 3 cycles apart; mem_cs never high in two consecutive cycles.
REQ-038 Contention, PRIO_MODE=1: both reqs held high -> only m0 is acked; m1 is served only after m0_req drops.
REQ-039 Mid-flight change and reset: m0 requests addr 5; addr changes to 9 in ACCESS -> mem_addr=5. Separately, reset=0 in ACCESS -> no ack, all outputs at reset values, busy=0.
REQ-040 Dropped request: m1_req pulses for 1 cycle in IDLE -> transaction completes and m1_ack still pulses once.
